// File: rtl/etapa_busqueda.sv
// -----------------------------------------------------------------------------
// etapa_busqueda
//   Instruction-fetch stage of a 5-stage MIPS pipeline. Owns the program
//   counter, presents it to instruction memory, and latches the returned word
//   together with PC+4 into the IF/ID pipeline register. Supports hazard
//   stalls, PC redirects (branch / jump / jr), IF/ID flushes and a halt word
//   that freezes fetching until the next redirect.
//
// Ports
//   clk                in   system clock, rising-edge active
//   reset              in   asynchronous, active-high reset
//   stall              in   hold PC and IF/ID this cycle
//   flush              in   write a bubble into IF/ID
//   pc_src       [1:0] in   00 PC+4, 01 dir_salto, 10 dir_jump, 11 dir_registro
//   dir_salto   [31:0] in   branch target
//   dir_jump    [31:0] in   jump target
//   dir_registro[31:0] in   jr target
//   instruccion [31:0] in   word returned by instruction memory (same cycle)
//   direccion   [31:0] out  current PC, to instruction memory
//   if_id_instruccion  out  IF/ID instruction
//   if_id_pc_mas4      out  IF/ID PC+4
//   if_id_valido       out  IF/ID holds a real instruction
//   detenido           out  high while fetching is halted
//   contador_instr     out  number of valid instructions loaded into IF/ID
// -----------------------------------------------------------------------------
module etapa_busqueda #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pc_src,
    input  logic [31:0] dir_salto,
    input  logic [31:0] dir_jump,
    input  logic [31:0] dir_registro,
    input  logic [31:0] instruccion,
    output logic [31:0] direccion,
    output logic [31:0] if_id_instruccion,
    output logic [31:0] if_id_pc_mas4,
    output logic        if_id_valido,
    output logic        detenido,
    output logic [31:0] contador_instr
);

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StHalt = 1'b1
    } state_e;

    // Word alignment is enforced on every value that can reach the PC.
    localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] target;
    logic [31:0] pc_mas4;
    logic        redirect;
    logic        is_halt_word;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    always_comb begin
        target = 32'h0;
        unique case (pc_src)
            2'b01:   target = dir_salto & AlignMask;
            2'b10:   target = dir_jump & AlignMask;
            2'b11:   target = dir_registro & AlignMask;
            default: target = 32'h0;
        endcase
    end

    assign pc_mas4      = pc_q + 32'd4;  // modulo 2^32, wraps to 0
    assign redirect     = (pc_src != 2'b00);
    assign is_halt_word = (instruccion == HALT_WORD);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            StRun: begin
                // IF/ID: flush beats stall; otherwise load the fetched word,
                // including the halt word itself.
                if (flush) begin
                    ifid_instr_d = NOP_WORD;
                    ifid_pc4_d   = 32'h0;
                    ifid_valid_d = 1'b0;
                end else if (!stall) begin
                    ifid_instr_d = instruccion;
                    ifid_pc4_d   = pc_mas4;
                    ifid_valid_d = 1'b1;
                    cnt_d        = cnt_q + 32'd1;
                end

                // PC: a redirect beats stall and suppresses a halt. A flush in
                // the same cycle as the halt word means that word is being
                // squashed, so it must not freeze fetching.
                if (redirect) begin
                    pc_d = target;
                end else if (!stall) begin
                    if (is_halt_word && !flush) begin
                        state_d = StHalt;
                    end else begin
                        pc_d = pc_mas4;
                    end
                end
            end

            StHalt: begin
                // While halted, IF/ID drains to bubbles unless held by a stall.
                if (flush || !stall) begin
                    ifid_instr_d = NOP_WORD;
                    ifid_pc4_d   = 32'h0;
                    ifid_valid_d = 1'b0;
                end

                // Only a redirect leaves the halt; stall does not block it.
                if (redirect) begin
                    pc_d    = target;
                    state_d = StRun;
                end
            end

            default: begin
                state_d = StRun;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC & AlignMask;
            ifid_instr_q <= NOP_WORD;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
            cnt_q        <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign direccion         = pc_q;
    assign if_id_instruccion = ifid_instr_q;
    assign if_id_pc_mas4     = ifid_pc4_q;
    assign if_id_valido      = ifid_valid_q;
    assign detenido          = (state_q == StHalt);
    assign contador_instr    = cnt_q;

endmodule

// File: tb/tb_etapa_busqueda.sv
// -----------------------------------------------------------------------------
// tb_etapa_busqueda
//   Directed bench for etapa_busqueda. A reference model of the fetch stage
//   advances once per rising edge; all outputs are compared against it after
//   every edge, and literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_etapa_busqueda;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [1:0]  pc_src;
    logic [31:0] dir_salto;
    logic [31:0] dir_jump;
    logic [31:0] dir_registro;
    logic [31:0] instruccion;
    logic [31:0] direccion;
    logic [31:0] if_id_instruccion;
    logic [31:0] if_id_pc_mas4;
    logic        if_id_valido;
    logic        detenido;
    logic [31:0] contador_instr;

    // 128-word instruction memory, addressed by bits [8:2].
    logic [31:0] mem [0:127];

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_halted;
    logic [31:0] m_cnt;

    etapa_busqueda dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .flush             (flush),
        .pc_src            (pc_src),
        .dir_salto         (dir_salto),
        .dir_jump          (dir_jump),
        .dir_registro      (dir_registro),
        .instruccion       (instruccion),
        .direccion         (direccion),
        .if_id_instruccion (if_id_instruccion),
        .if_id_pc_mas4     (if_id_pc_mas4),
        .if_id_valido      (if_id_valido),
        .detenido          (detenido),
        .contador_instr    (contador_instr)
    );

    assign instruccion = mem[direccion[8:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem[a[8:2]];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, want %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = 32'h0;
        m_instr  = 32'h0;
        m_pc4    = 32'h0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_cnt    = 32'h0;
    endtask

    // One rising edge of the fetch stage as described behaviourally.
    task automatic model_edge();
        logic [31:0] tgt;
        logic [31:0] word;
        logic        bubble;
        logic        load;
        tgt = (pc_src == 2'd1) ? dir_salto : (pc_src == 2'd2) ? dir_jump : dir_registro;
        tgt = {tgt[31:2], 2'b00};
        word = rd(m_pc);
        bubble = m_halted ? (flush || !stall) : flush;
        load   = !m_halted && !flush && !stall;
        if (bubble) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (load) begin
            m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 1;
        end
        if (pc_src != 2'b00) begin
            m_pc = tgt;
            m_halted = 1'b0;
        end else if (!m_halted && !stall) begin
            if (word == HALT && !flush) m_halted = 1'b1;
            else m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all();
        check("direccion", direccion, m_pc);
        check("if_id_instruccion", if_id_instruccion, m_instr);
        check("if_id_pc_mas4", if_id_pc_mas4, m_pc4);
        check("if_id_valido", {31'b0, if_id_valido}, {31'b0, m_valid});
        check("detenido", {31'b0, detenido}, {31'b0, m_halted});
        check("contador_instr", contador_instr, m_cnt);
    endtask

    // Drive inputs after a falling edge, advance one rising edge, compare.
    task automatic step(input logic s, input logic f, input logic [1:0] src,
                        input logic [31:0] ds, input logic [31:0] dj,
                        input logic [31:0] dr);
        stall = s; flush = f; pc_src = src;
        dir_salto = ds; dir_jump = dj; dir_registro = dr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0; flush = 1'b0; pc_src = 2'b00;
        #1;
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h2000_0000 | (i << 2);
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0000_000A;
        stall = 1'b0; flush = 1'b0; pc_src = 2'b00;
        dir_salto = 32'h0; dir_jump = 32'h0; dir_registro = 32'h0;
        reset = 1'b1;
        model_reset();
        #2;
        check("reset direccion", direccion, 32'h0);
        check("reset valido", {31'b0, if_id_valido}, 32'h0);
        check("reset instr", if_id_instruccion, 32'h0);
        check("reset contador", contador_instr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        compare_all();

        // Free-run and stall at PC = 8.
        run(1);
        check("first fetch instr", if_id_instruccion, 32'h2008_0001);
        check("first fetch pc4", if_id_pc_mas4, 32'h4);
        run(1);
        check("pc at 8", direccion, 32'h8);
        step(1'b1, 1'b0, 2'b00, 0, 0, 0);
        step(1'b1, 1'b0, 2'b00, 0, 0, 0);
        check("stall pc", direccion, 32'h8);
        check("stall instr", if_id_instruccion, 32'h2009_0002);
        check("stall pc4", if_id_pc_mas4, 32'h8);
        check("stall contador", contador_instr, 32'd2);
        run(1);
        check("resume instr", if_id_instruccion, 32'h0000_000A);
        check("three loads", contador_instr, 32'd3);
        run(1);
        check("pc at 0x10", direccion, 32'h10);

        // Branch with flush, then jump under stall.
        step(1'b0, 1'b1, 2'b01, 32'h40, 0, 0);
        check("branch pc", direccion, 32'h40);
        check("flush valido", {31'b0, if_id_valido}, 32'h0);
        run(1);
        check("branch target load", if_id_instruccion, 32'h2000_0040);
        step(1'b1, 1'b0, 2'b10, 0, 32'h103, 0);
        check("jump over stall", direccion, 32'h100);
        check("jump stall holds", if_id_instruccion, 32'h2000_0040);

        // PC+4 wrap-around.
        step(1'b0, 1'b0, 2'b11, 0, 0, 32'hFFFF_FFFF);
        check("jr aligned", direccion, 32'hFFFF_FFFC);
        run(1);
        check("wrap pc", direccion, 32'h0);
        check("wrap pc4", if_id_pc_mas4, 32'h0);

        // Halt word at 0x0C.
        mem[3] = HALT;
        do_reset();
        run(4);
        check("halt latched", if_id_instruccion, HALT);
        check("halt valido", {31'b0, if_id_valido}, 32'h1);
        check("halt detenido", {31'b0, detenido}, 32'h1);
        check("halt pc", direccion, 32'hC);
        run(1);
        check("halt bubble", {31'b0, if_id_valido}, 32'h0);
        check("halt frozen", direccion, 32'hC);
        step(1'b1, 1'b0, 2'b00, 0, 0, 0);
        step(1'b0, 1'b1, 2'b00, 0, 0, 0);
        check("flush keeps halt", {31'b0, detenido}, 32'h1);
        step(1'b1, 1'b0, 2'b11, 0, 0, 32'h20);
        check("jr exits halt", direccion, 32'h20);
        check("detenido drops", {31'b0, detenido}, 32'h0);
        run(1);
        check("after halt contador", contador_instr, 32'd5);

        // Halt suppressed by flush, then by redirect.
        do_reset();
        run(3);
        step(1'b0, 1'b1, 2'b00, 0, 0, 0);
        check("flush suppresses halt", direccion, 32'h10);
        do_reset();
        run(3);
        step(1'b0, 1'b0, 2'b01, 32'h40, 0, 0);
        check("redirect suppresses halt", {31'b0, detenido}, 32'h0);
        check("redirect halt latched", if_id_instruccion, HALT);

        // Asynchronous reset mid-cycle at PC = 0x24 with nine loads.
        mem[3] = 32'h2000_000C;
        do_reset();
        run(9);
        check("pre-reset pc", direccion, 32'h24);
        check("pre-reset contador", contador_instr, 32'd9);
        #2;
        reset = 1'b1;
        #1;
        check("async direccion", direccion, 32'h0);
        check("async contador", contador_instr, 32'h0);
        check("async valido", {31'b0, if_id_valido}, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        compare_all();
        run(1);
        check("resume after reset", direccion, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/etapa_busqueda.md
Name: etapa_busqueda

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the program counter and drives `direccion` into memoriaDeInstrucciones.
- Latches the returned `instruccion` into the IF/ID pipeline register.
- Handles stalls, PC redirects (branch/jump/jr), IF/ID flushes, and a halt word that freezes fetching.

Parameters:
RESET_PC  32'h00000000  PC value loaded on reset
HALT_WORD  32'hFFFFFFFF  instruction encoding that stops fetching
NOP_WORD  32'h00000000  bubble written into IF/ID on flush/halt

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID this cycle
flush  input  1  squash IF/ID contents (write bubble)
pc_src  input  2  00 PC+4, 01 dir_salto, 10 dir_jump, 11 dir_registro
dir_salto  input  32  branch target
dir_jump  input  32  jump target
dir_registro  input  32  jr target
instruccion  input  32  word returned by instruction memory
direccion  output  32  current PC, to instruction memory
if_id_instruccion  output  32  IF/ID instruction
if_id_pc_mas4  output  32  IF/ID PC+4
if_id_valido  output  1  IF/ID holds a real instruction
detenido  output  1  high while in S_HALT
contador_instr  output  32  count of valid instructions loaded into IF/ID

Behaviour:
- Clock and reset: one clock `clk`. `reset` is asynchronous and active-high.
- Reset values:
  - PC = RESET_PC.
  - if_id_instruccion = NOP_WORD, if_id_pc_mas4 = 0, if_id_valido = 0.
  - detenido = 0, contador_instr = 0.
  - FSM = S_RUN.
- Memory interface:
  - direccion = PC, combinational.
  - Instruction memory returns `instruccion` in the same cycle.
  - direccion[1:0] is always 00; target inputs have bits [1:0] forced to 0.
- Arithmetic: PC+4 is 32-bit modulo. 32'hFFFFFFFC + 4 wraps to 0.
- Target mux: target = dir_salto / dir_jump / dir_registro per pc_src.
- S_RUN, PC update at rising edge, in priority order:
  - pc_src != 00 → PC <= target. Redirect overrides stall.
  - else stall → PC holds.
  - else instruccion == HALT_WORD and !flush → PC holds, FSM -> S_HALT.
  - else PC <= PC+4.
- S_RUN, IF/ID update at rising edge, in priority order:
  - flush → NOP_WORD, valido 0, pc_mas4 0. Flush overrides stall.
  - else stall → hold all IF/ID fields.
  - else load instruccion, PC+4, valido 1.
  - The halt word itself is latched into IF/ID with valido 1.
- Redirect and flush are independent:
  - A redirect does not flush IF/ID on its own; the hazard unit asserts flush when needed.
  - A redirect in the same cycle as HALT_WORD suppresses the halt.
- S_HALT:
  - detenido = 1; PC holds.
  - IF/ID: flush or !stall → bubble; stall && !flush → hold.
  - pc_src != 00 → PC <= target, FSM -> S_RUN. detenido drops on the following cycle.
  - flush alone does not exit S_HALT.
  - stall does not block the exit.
- contador_instr:
  - Increments by 1 on every edge where IF/ID loads with valido = 1.
  - A held register (stall) does not count.
  - Wraps modulo 2^32.
- Reset mid-operation:
  - All state returns to reset values immediately, without waiting for a clock edge.
  - Fetch resumes at RESET_PC on the first edge after reset deasserts.

Test Plan:
- Reset then free-run, memory preloaded 0x20080001, 0x20090002, 0x0000000A at 0, 4, 8:
  - direccion sequence 0, 4, 8, 12.
  - IF/ID shows 0x20080001 with pc_mas4 = 4 one cycle after direccion = 0.
  - contador_instr = 3 after 3 edges.
- stall high for 2 cycles at PC = 8:
  - direccion stays 8 and IF/ID holds the word from address 4, pc_mas4 = 8.
  - contador does not advance.
  - Fetch resumes at 8 afterwards.
- pc_src = 01, dir_salto = 0x40, flush = 1 together at PC = 0x10:
  - next direccion = 0x40.
  - IF/ID = 0, valido 0.
  - Next edge loads the word at 0x40.
- pc_src = 10 with stall = 1 and dir_jump = 0x103:
  - PC = 0x100 (low bits cleared), redirect wins over stall.
  - IF/ID holds.
- HALT_WORD at 0x0C:
  - IF/ID latches 0xFFFFFFFF, valido 1; detenido = 1.
  - direccion frozen at 0x0C; later IF/ID shows bubbles.
  - pc_src = 11 with dir_registro = 0x20 → direccion 0x20, detenido = 0.
- reset asserted asynchronously mid-cycle at PC = 0x24 with contador = 9:
  - direccion = RESET_PC, contador = 0, valido 0 immediately, before any edge.
